// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-wrap and width helpers plus default thresholds for fifo_buffer
package fifo_pkg;

    localparam int DEF_AEMPTY_TH     = 1;
    localparam int DEF_AFULL_MARGIN  = 1;

    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int pw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int ptr_wrap(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer register over 0..DEPTH-1, explicit wrap so any DEPTH works
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = pw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // advance by one on inc, jumping from DEPTH-1 back to 0
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (inc) ptr <= PW'(ptr_wrap(int'(ptr), DEPTH));

endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: parametrised show-ahead synchronous FIFO with count and thresholds; FIFO_BUF_ERR_EN adds sticky ovf/udf
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter  int BITS      = 8,
    parameter  int DEPTH     = 4,
    parameter  int AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
    parameter  int AEMPTY_TH = DEF_AEMPTY_TH,
    localparam int CW        = cw_of(DEPTH),
    localparam int PW        = pw_of(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [BITS-1:0] Din,
    input  logic            pop,
`ifdef FIFO_BUF_ERR_EN
    input  logic            err_clr,
    output logic            ovf,
    output logic            udf,
`endif
    output logic [BITS-1:0] Dout,
    output logic            full,
    output logic            pndng,
    output logic [CW-1:0]   count,
    output logic            almost_full,
    output logic            almost_empty
);

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   wp, rp;
    logic            wr, rd;

    assign wr = push && (!full || pop);
    assign rd = pop && pndng;

    fifo_ptr #(.DEPTH(DEPTH)) u_wp (.clk(clk), .rst(rst), .inc(wr), .ptr(wp));
    fifo_ptr #(.DEPTH(DEPTH)) u_rp (.clk(clk), .rst(rst), .inc(rd), .ptr(rp));

    // storage is deliberately left unreset; pointers alone define validity
    always_ff @(posedge clk)
        if (wr) mem[wp] <= Din;

    // occupancy moves only when exactly one side is accepted
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (wr && !rd) count <= count + CW'(1);
        else if (rd && !wr) count <= count - CW'(1);

    assign full         = count == CW'(DEPTH);
    assign pndng        = count != '0;
    assign almost_full  = count >= CW'(AFULL_TH);
    assign almost_empty = count <= CW'(AEMPTY_TH);
    assign Dout         = pndng ? mem[rp] : '0;

`ifdef FIFO_BUF_ERR_EN
    logic ovf_set, udf_set;

    assign ovf_set = push && full && !pop;
    assign udf_set = pop && !pndng;

    // sticky error flags, a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf_set ? 1'b1 : err_clr ? 1'b0 : ovf;
            udf <= udf_set ? 1'b1 : err_clr ? 1'b0 : udf;
        end
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed plus seeded traffic against a queue model of fifo_buffer (BITS=8, DEPTH=5)
module tb_fifo_buffer;

    localparam int BITS  = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [BITS-1:0] Din = '0;
    logic [BITS-1:0] Dout;
    logic            full, pndng, almost_full, almost_empty;
    logic [CW-1:0]   count;
`ifdef FIFO_BUF_ERR_EN
    logic            ovf, udf;
`endif

    int tests = 0;
    int fails = 0;
    bit en = 1'b0;

    logic [BITS-1:0] q[$];
    bit m_ovf = 1'b0, m_udf = 1'b0;

    fifo_buffer #(.BITS(BITS), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
        .clk(clk), .rst(rst), .push(push), .Din(Din), .pop(pop),
`ifdef FIFO_BUF_ERR_EN
        .err_clr(err_clr), .ovf(ovf), .udf(udf),
`endif
        .Dout(Dout), .full(full), .pndng(pndng), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic step(input bit p, input logic [BITS-1:0] d, input bit r, input bit c);
        bit wok, rok, oset, uset;
        push = p; Din = d; pop = r; err_clr = c;
        wok  = p && (q.size() < DEPTH || r);
        rok  = r && q.size() > 0;
        oset = p && !r && q.size() == DEPTH;
        uset = r && q.size() == 0;
        @(posedge clk);
        if (rok) void'(q.pop_front());
        if (wok) q.push_back(d);
        m_ovf = oset ? 1'b1 : c ? 1'b0 : m_ovf;
        m_udf = uset ? 1'b1 : c ? 1'b0 : m_udf;
        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    // every falling edge the DUT must match the queue model
    always @(negedge clk)
        if (en) begin
            chk("count", int'(count), q.size());
            chk("pndng", int'(pndng), int'(q.size() != 0));
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("almost_full", int'(almost_full), int'(q.size() >= AF));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= AE));
            chk("dout", int'(Dout), q.size() != 0 ? int'(q[0]) : 0);
`ifdef FIFO_BUF_ERR_EN
            chk("ovf", int'(ovf), int'(m_ovf));
            chk("udf", int'(udf), int'(m_udf));
`endif
        end

    task automatic lit_idle(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_pndng"}, int'(pndng), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_aempty"}, int'(almost_empty), 1);
        chk({tag, "_afull"}, int'(almost_full), 0);
        chk({tag, "_dout"}, int'(Dout), 0);
    endtask

    initial begin
        logic [BITS-1:0] tail [5];
        tail[0] = 8'h22; tail[1] = 8'h23; tail[2] = 8'h24; tail[3] = 8'h25; tail[4] = 8'hBB;
        #12;
        lit_idle("reset");
`ifdef FIFO_BUF_ERR_EN
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_udf", int'(udf), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 5);
        chk("fill_head", int'(Dout), 8'h11);

        for (int i = 0; i < 5; i++) begin
            chk("drain1_dout", int'(Dout), 8'h11 + i);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        lit_idle("drained");

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        chk("wrap_full", int'(full), 1);
        chk("wrap_head", int'(Dout), 8'h21);

        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_count", int'(count), 5);
        chk("ovf_head", int'(Dout), 8'h21);
`ifdef FIFO_BUF_ERR_EN
        chk("ovf_flag", int'(ovf), 1);
`endif
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        chk("pp_full_count", int'(count), 5);
        chk("pp_full_head", int'(Dout), 8'h22);
        for (int i = 0; i < 5; i++) begin
            chk("drain2_dout", int'(Dout), int'(tail[i]));
            step(1'b0, '0, 1'b1, 1'b0);
        end

        step(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("udf_count", int'(count), 1);
        chk("udf_head", int'(Dout), 8'h3C);
`ifdef FIFO_BUF_ERR_EN
        chk("udf_flag", int'(udf), 1);
`endif
        step(1'b0, '0, 1'b1, 1'b0);

        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk("th_count", int'(count), i);
            chk("th_aempty", int'(almost_empty), int'(i <= 1));
            chk("th_afull", int'(almost_full), int'(i >= 4));
        end

        step(1'b0, '0, 1'b0, 1'b1);
`ifdef FIFO_BUF_ERR_EN
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_udf", int'(udf), 0);
`endif
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b1);
        chk("clr_set_count", int'(count), 5);
        chk("clr_set_head", int'(Dout), 1);
`ifdef FIFO_BUF_ERR_EN
        chk("clr_set_ovf", int'(ovf), 1);
`endif

        #2 rst = 1'b1;
        model_reset();
        #1 lit_idle("async_rst");
`ifdef FIFO_BUF_ERR_EN
        chk("async_rst_ovf", int'(ovf), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);

        en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parametrised synchronous FIFO that replaces the fixed 8-bit/4-deep `fifo` shell with a working, generalised buffer. It has arbitrary width and depth (non-power-of-2 included), an occupancy count, programmable almost-full/almost-empty thresholds, and optional sticky error reporting. It sits between a producer and a consumer in the same clock domain and is the standard buffer for later datapath blocks.

## Interface
- `BITS`, default 8: data word width, ≥1.
- `DEPTH`, default 4: number of storage entries, ≥2; need not be a power of two.
- `AFULL_TH`, default DEPTH-1: `almost_full` asserts when count ≥ AFULL_TH.
- `AEMPTY_TH`, default 1: `almost_empty` asserts when count ≤ AEMPTY_TH.
- `CW` (derived, localparam): $clog2(DEPTH+1).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous assert, active-high.
- `push` input 1: write request; `Din` is captured at the clock edge.
- `Din` input BITS: write data.
- `pop` input 1: read request; consumes the head word at the clock edge.
- `Dout` output BITS: head word, show-ahead; 0 when empty.
- `full` output 1: count == DEPTH.
- `pndng` output 1: count != 0 (data pending).
- `count` output CW: current occupancy, 0..DEPTH.
- `almost_full` output 1: count ≥ AFULL_TH.
- `almost_empty` output 1: count ≤ AEMPTY_TH.
- `ovf` output 1: sticky overflow flag. Present only with FIFO_BUF_ERR_EN.
- `udf` output 1: sticky underflow flag. Present only with FIFO_BUF_ERR_EN.
- `err_clr` input 1: synchronous clear of `ovf`/`udf`. Present only with FIFO_BUF_ERR_EN.

## Operation
- State: write pointer `wp`, read pointer `rp` (each 0..DEPTH-1), `count` register, storage array of DEPTH×BITS. The storage is not reset.
- Reset values: wp=rp=0, count=0. Outputs after reset: full=0, pndng=0, almost_full=0 (if AFULL_TH>0), almost_empty=1, Dout=0, ovf=udf=0.
- Pointer advance: p_next = (p == DEPTH-1) ? 0 : p+1. This is an explicit wrap and must not rely on binary overflow.
- Accepted push: push && (!full || pop). The write stores Din at mem[wp] and advances wp.
- Accepted pop: pop && pndng. The pop advances rp.
- Count update: +1 on push only, −1 on pop only, unchanged when both are accepted.
- Push while full and pop=0: ignored. No state change. Sets ovf.
- Push and pop while full: both accepted. The head leaves, new data enters, count stays at DEPTH.
- Pop while empty (with or without push): the pop is ignored and sets udf. A simultaneous push is still accepted, giving count=1. There is no same-cycle bypass to Dout.
- Dout = pndng ? mem[rp] : 0. It is combinational from the registered pointers.
- Status outputs are combinational decodes of the registered `count` only.
- Reset asserted mid-operation: pointers and count clear immediately (asynchronously). Stored words are discarded logically; Dout reads 0.

## Timing
- Write-to-read latency: a word pushed at edge N is visible on Dout and counted by pndng after edge N (i.e. in cycle N+1), provided it is the head.
- Pop effect: after the edge, Dout shows the next word, or 0 if the FIFO became empty.
- full/pndng/count/almost_* update in the same cycle as the pointer change, with no extra registration.
- Throughput: one push and one pop per cycle sustained, including at full and at empty+1.
- Reset: asynchronous assertion; deassertion is synchronous to `clk` by the system. The first accepted operation is on the first rising edge with rst=0.

## Configuration
- Macro `FIFO_BUF_ERR_EN`.
- With the macro defined: `ovf`, `udf` and `err_clr` exist. Flags set on the rejected-push and rejected-pop conditions above and stay set until `err_clr`=1 at an edge. If set and clear occur in the same cycle, set wins. Both flags reset to 0.
- Without the macro: the ports and registers are absent. Rejected operations are silently dropped, and all other behaviour is identical.

## Structure
- Shared package `fifo_pkg`: the pointer-wrap function, a CW width helper function, and the default threshold constants.
- One sub-module, `fifo_ptr`: a wrapping pointer register with parameter DEPTH, inputs clk/rst/inc, output ptr. It is instantiated twice (wp, rp).
- Storage, count and status decode stay in `fifo_buffer`.

## Test plan
- Reset/idle: assert rst mid-stream with BITS=8, DEPTH=5 → count=0, pndng=0, full=0, almost_empty=1, Dout=0 immediately, without waiting for a clock edge.
- Fill/drain wrap: push 0x11..0x15, pop all, then push 0x21..0x25 → full after 5 pushes; Dout sequence 0x11..0x15 then 0x21..0x25; pointers wrap 4→0.
- Full boundary: at count=5, push 0xAA with pop=0 → ignored, count=5, ovf=1. Then push 0xBB with pop=1 → head popped, 0xBB stored at tail, count=5.
- Empty boundary: at count=0, pop=1 with push 0x3C → udf=1, count=1, Dout=0x3C on the next cycle.
- Thresholds: AFULL_TH=4, AEMPTY_TH=1, pushes one per cycle → almost_empty deasserts at count=2, almost_full asserts at count=4.
- Error clear: with ovf=1, pulse err_clr → ovf=0 next cycle. With err_clr and a rejected push in the same cycle → ovf stays 1. Build without FIFO_BUF_ERR_EN → the same stimulus gives identical data and count results.
